// File: rtl/gcbp_bram_reader.sv
// GCBP BRAM reader: walks all 16 gray-coded bit-plane sub-images line by line,
// fetching current- and previous-frame words and streaming them as valid/ready pairs.
module gcbp_bram_reader #(
   parameter int C_SUBIMAGE_HEIGHT = 64,
   parameter int C_NUM_SUBIMAGES   = 16,
   parameter int C_REGION_DEPTH    = 128,
   parameter int C_LINE_WIDTH      = 128
) (
   input  logic                                  i_clk,
   input  logic                                  i_resetn,
   input  logic                                  i_start,
   input  logic [1:0]                            i_curr_frame_loc,
   input  logic [1:0]                            i_prev_frame_loc,
   output logic [8:0]                            o_bram_array_read_addr,
   output logic [$clog2(C_NUM_SUBIMAGES)-1:0]    o_bram_array_read_sel,
   input  logic [C_LINE_WIDTH-1:0]               i_bram_array_read_data,
   output logic [C_LINE_WIDTH-1:0]               o_curr_line,
   output logic [C_LINE_WIDTH-1:0]               o_prev_line,
   output logic [$clog2(C_NUM_SUBIMAGES)-1:0]    o_subimage_idx,
   output logic [$clog2(C_SUBIMAGE_HEIGHT)-1:0]  o_line_idx,
   output logic                                  o_line_valid,
   input  logic                                  i_line_ready,
   output logic                                  o_last,
   output logic                                  o_busy,
   output logic                                  o_frame_done,
   output logic                                  o_start_overrun
);

   localparam int SUB_W  = $clog2(C_NUM_SUBIMAGES);
   localparam int LINE_W = $clog2(C_SUBIMAGE_HEIGHT);
   localparam logic [SUB_W-1:0]  LAST_SUB  = SUB_W'(C_NUM_SUBIMAGES - 1);
   localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(C_SUBIMAGE_HEIGHT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR_CURR,
      S_ADDR_PREV,
      S_CAP_PREV,
      S_OUT
   } state_t;

   state_t                    state_q, state_d;
   logic [1:0]                currLoc_q, currLoc_d;
   logic [1:0]                prevLoc_q, prevLoc_d;
   logic [SUB_W-1:0]          sub_q, sub_d;
   logic [LINE_W-1:0]         line_q, line_d;
   logic [8:0]                addr_q, addr_d;
   logic [SUB_W-1:0]          sel_q, sel_d;
   logic [C_LINE_WIDTH-1:0]   currLine_q, currLine_d;
   logic [C_LINE_WIDTH-1:0]   prevLine_q, prevLine_d;
   logic [SUB_W-1:0]          outSub_q, outSub_d;
   logic [LINE_W-1:0]         outLine_q, outLine_d;
   logic                      valid_q, valid_d;
   logic                      done_q, done_d;
   logic                      overrun_q, overrun_d;

   logic                      lastLine;
   logic [LINE_W-1:0]         nextLine;
   logic [SUB_W-1:0]          nextSub;

   // Each frame location owns a C_REGION_DEPTH-word region; lines sit at its base.
   function automatic logic [8:0] lineAddr(input logic [1:0] loc, input logic [LINE_W-1:0] line);
      return 9'(int'(loc) * C_REGION_DEPTH + int'(line));
   endfunction

   always_ff @(posedge i_clk or posedge i_resetn) begin
      if (i_resetn) begin
         state_q    <= S_IDLE;
         currLoc_q  <= '0;
         prevLoc_q  <= '0;
         sub_q      <= '0;
         line_q     <= '0;
         addr_q     <= '0;
         sel_q      <= '0;
         currLine_q <= '0;
         prevLine_q <= '0;
         outSub_q   <= '0;
         outLine_q  <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         currLoc_q  <= currLoc_d;
         prevLoc_q  <= prevLoc_d;
         sub_q      <= sub_d;
         line_q     <= line_d;
         addr_q     <= addr_d;
         sel_q      <= sel_d;
         currLine_q <= currLine_d;
         prevLine_q <= prevLine_d;
         outSub_q   <= outSub_d;
         outLine_q  <= outLine_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         overrun_q  <= overrun_d;
      end
   end

   // Address/select are registered one state ahead so the BRAM word lands in the capture state.
   always_comb begin
      state_d    = state_q;
      currLoc_d  = currLoc_q;
      prevLoc_d  = prevLoc_q;
      sub_d      = sub_q;
      line_d     = line_q;
      addr_d     = addr_q;
      sel_d      = sel_q;
      currLine_d = currLine_q;
      prevLine_d = prevLine_q;
      outSub_d   = outSub_q;
      outLine_d  = outLine_q;
      valid_d    = valid_q;
      done_d     = 1'b0;
      overrun_d  = i_start && (state_q != S_IDLE);
      lastLine   = (line_q == LAST_LINE);
      nextLine   = lastLine ? '0 : line_q + 1'b1;
      nextSub    = lastLine ? sub_q + 1'b1 : sub_q;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               currLoc_d = i_curr_frame_loc;
               prevLoc_d = i_prev_frame_loc;
               sub_d     = '0;
               line_d    = '0;
               addr_d    = lineAddr(i_curr_frame_loc, '0);
               sel_d     = '0;
               state_d   = S_ADDR_CURR;
            end
         end
         S_ADDR_CURR: begin
            addr_d  = lineAddr(prevLoc_q, line_q);
            state_d = S_ADDR_PREV;
         end
         S_ADDR_PREV: begin
            currLine_d = i_bram_array_read_data;
            state_d    = S_CAP_PREV;
         end
         S_CAP_PREV: begin
            prevLine_d = i_bram_array_read_data;
            outSub_d   = sub_q;
            outLine_d  = line_q;
            valid_d    = 1'b1;
            state_d    = S_OUT;
         end
         S_OUT: begin
            if (i_line_ready) begin
               valid_d = 1'b0;
               if (lastLine && (sub_q == LAST_SUB)) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  line_d  = nextLine;
                  sub_d   = nextSub;
                  addr_d  = lineAddr(currLoc_q, nextLine);
                  sel_d   = nextSub;
                  state_d = S_ADDR_CURR;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign o_bram_array_read_addr = addr_q;
   assign o_bram_array_read_sel  = sel_q;
   assign o_curr_line            = currLine_q;
   assign o_prev_line            = prevLine_q;
   assign o_subimage_idx         = outSub_q;
   assign o_line_idx             = outLine_q;
   assign o_line_valid           = valid_q;
   assign o_last                 = valid_q && (outSub_q == LAST_SUB) && (outLine_q == LAST_LINE);
   assign o_busy                 = (state_q != S_IDLE);
   assign o_frame_done           = done_q;
   assign o_start_overrun        = overrun_q;

endmodule

// File: tb/tb_gcbp_bram_reader.sv
// Self-checking bench for gcbp_bram_reader: synchronous BRAM model, pair scoreboard,
// table of whole-frame runs plus hand sequences for overrun and mid-frame reset.
module tb_gcbp_bram_reader;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [1:0]   currLoc = '0;
   logic [1:0]   prevLoc = '0;
   logic [8:0]   readAddr;
   logic [3:0]   readSel;
   logic [127:0] readData = '0;
   logic [127:0] currLine;
   logic [127:0] prevLine;
   logic [3:0]   subIdx;
   logic [5:0]   lineIdx;
   logic         lineValid;
   logic         lineReady = 1'b0;
   logic         last;
   logic         busy;
   logic         frameDone;
   logic         startOverrun;

   typedef struct {
      logic [127:0] curr;
      logic [127:0] prev;
      logic [3:0]   idx;
      logic [5:0]   line;
   } pair_t;

   typedef struct {
      logic [1:0] curr;
      logic [1:0] prev;
      int         readyPct;
      logic [8:0] expFirstAddr;
      logic [8:0] expSecondAddr;
      int         expCycles;
   } vec_t;

   pair_t        sb[$];
   pair_t        monEntry;
   vec_t         vecs[4];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           readyPct = 100;
   int           pairCount = 0;
   int           lastCount = 0;
   int           doneCount = 0;
   int           overrunCount = 0;
   logic         holdPending = 1'b0;
   logic [271:0] holdSnap = '0;

   gcbp_bram_reader dut (
      .i_clk                  (clk),
      .i_resetn               (rst),
      .i_start                (start),
      .i_curr_frame_loc       (currLoc),
      .i_prev_frame_loc       (prevLoc),
      .o_bram_array_read_addr (readAddr),
      .o_bram_array_read_sel  (readSel),
      .i_bram_array_read_data (readData),
      .o_curr_line            (currLine),
      .o_prev_line            (prevLine),
      .o_subimage_idx         (subIdx),
      .o_line_idx             (lineIdx),
      .o_line_valid           (lineValid),
      .i_line_ready           (lineReady),
      .o_last                 (last),
      .o_busy                 (busy),
      .o_frame_done           (frameDone),
      .o_start_overrun        (startOverrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Every word encodes its own BRAM select and address so misreads are visible.
   function automatic logic [127:0] bramWord(input logic [3:0] sel, input logic [8:0] addr);
      logic [15:0] w;
      w = {sel, addr, 3'b101};
      return {8{w}};
   endfunction

   always @(posedge clk) readData <= bramWord(readSel, readAddr);

   always @(posedge clk) begin
      #1;
      lineReady = ($urandom_range(0, 99) < readyPct);
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic pushFrame(input logic [1:0] c, input logic [1:0] p);
      pair_t e;
      for (int s = 0; s < 16; s++) begin
         for (int l = 0; l < 64; l++) begin
            e.idx  = 4'(s);
            e.line = 6'(l);
            e.curr = bramWord(4'(s), 9'(int'(c) * 128 + l));
            e.prev = bramWord(4'(s), 9'(int'(p) * 128 + l));
            sb.push_back(e);
         end
      end
   endtask

   // Monitor: pops the scoreboard on each handshake and checks stalled outputs stay put.
   always @(negedge clk) begin
      if (rst) begin
         holdPending = 1'b0;
      end else begin
         if (holdPending)
            checkOutput("holdStable", {lineValid, subIdx, lineIdx, currLine, prevLine}, holdSnap[266:0]);
         if (lineValid && lineReady) begin
            if (sb.size() == 0) begin
               checkOutput("unexpectedPair", 1, 0);
            end else begin
               monEntry = sb.pop_front();
               checkOutput("pairIdx", {subIdx, lineIdx}, {monEntry.idx, monEntry.line});
               checkOutput("currLine", currLine, monEntry.curr);
               checkOutput("prevLine", prevLine, monEntry.prev);
               checkOutput("lastFlag", last, (monEntry.idx == 4'd15) && (monEntry.line == 6'd63));
            end
            pairCount++;
            if (last) lastCount++;
         end
         holdPending = lineValid && !lineReady;
         holdSnap    = {5'b0, lineValid, subIdx, lineIdx, currLine, prevLine};
         if (frameDone) doneCount++;
         if (startOverrun) overrunCount++;
      end
   end

   task automatic pulseStart(input logic [1:0] c, input logic [1:0] p, output int startCyc);
      @(posedge clk);
      #1;
      start   = 1'b1;
      currLoc = c;
      prevLoc = p;
      @(posedge clk);
      #1;
      start    = 1'b0;
      startCyc = cyc;
   endtask

   task automatic applyStimulus(input vec_t v);
      int  startCyc;
      int  pairBase, lastBase, doneBase, ovrBase;
      bit  done;
      readyPct = v.readyPct;
      pairBase = pairCount;
      lastBase = lastCount;
      doneBase = doneCount;
      ovrBase  = overrunCount;
      pushFrame(v.curr, v.prev);
      pulseStart(v.curr, v.prev, startCyc);
      checkOutput("busyAfterStart", busy, 1);
      checkOutput("firstAddr", {readSel, readAddr}, {4'd0, v.expFirstAddr});
      @(posedge clk); #1;
      checkOutput("secondAddr", {readSel, readAddr}, {4'd0, v.expSecondAddr});
      @(posedge clk); #1;
      checkOutput("validCycle2", lineValid, 0);
      @(posedge clk); #1;
      checkOutput("validCycle3", {lineValid, subIdx, lineIdx}, {1'b1, 4'd0, 6'd0});
      done = 0;
      for (int n = 0; n < 20000 && !done; n++) begin
         @(posedge clk); #1;
         if (frameDone) done = 1;
      end
      checkOutput("frameDoneSeen", done, 1);
      if (done && v.expCycles != 0)
         checkOutput("frameCycles", cyc - startCyc, v.expCycles);
      checkOutput("busyAfterDone", busy, 0);
      @(negedge clk); #1;
      checkOutput("pairCount", pairCount - pairBase, 1024);
      checkOutput("lastCount", lastCount - lastBase, 1);
      checkOutput("doneCount", doneCount - doneBase, 1);
      checkOutput("overrunCount", overrunCount - ovrBase, 0);
      checkOutput("sbEmpty", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      int  startCyc;
      int  doneBase, ovrBase, pairBase;
      bit  found;

      vecs[0] = '{curr: 2'd1, prev: 2'd0, readyPct: 100, expFirstAddr: 9'd128, expSecondAddr: 9'd0,   expCycles: 4096};
      vecs[1] = '{curr: 2'd2, prev: 2'd1, readyPct: 100, expFirstAddr: 9'd256, expSecondAddr: 9'd128, expCycles: 4096};
      vecs[2] = '{curr: 2'd0, prev: 2'd3, readyPct: 30,  expFirstAddr: 9'd0,   expSecondAddr: 9'd384, expCycles: 0};
      vecs[3] = '{curr: 2'd3, prev: 2'd3, readyPct: 100, expFirstAddr: 9'd384, expSecondAddr: 9'd384, expCycles: 4096};

      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetOutputs", {lineValid, busy, readAddr, readSel, subIdx, lineIdx, last, frameDone, startOverrun}, 0);
      checkOutput("resetLines", {currLine, prevLine}, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

      // Overrun mid-frame and on the final handshake cycle.
      readyPct = 100;
      doneBase = doneCount;
      ovrBase  = overrunCount;
      pairBase = pairCount;
      pushFrame(2'd2, 2'd1);
      pulseStart(2'd2, 2'd1, startCyc);
      repeat (499) @(posedge clk);
      #1;
      start = 1'b1; currLoc = 2'd0; prevLoc = 2'd0;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("overrunMid", {startOverrun, busy}, 2'b11);
      @(posedge clk); #1;
      checkOutput("overrunPulseWidth", startOverrun, 0);
      repeat (3594) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("overrunFinal", {startOverrun, frameDone, busy}, 3'b110);
      @(posedge clk); #1;
      checkOutput("startIgnoredAtEnd", {busy, frameDone, startOverrun}, 0);
      checkOutput("overrunCountSeq", overrunCount - ovrBase, 2);
      checkOutput("doneCountSeq", doneCount - doneBase, 1);
      checkOutput("pairCountSeq", pairCount - pairBase, 1024);
      sb.delete();

      // Asynchronous reset while presenting sub-image 7 / line 30.
      pushFrame(2'd1, 2'd2);
      pulseStart(2'd1, 2'd2, startCyc);
      found = 0;
      for (int n = 0; n < 5000 && !found; n++) begin
         @(posedge clk); #1;
         if (lineValid && subIdx == 4'd7 && lineIdx == 6'd30) found = 1;
      end
      checkOutput("reachedIdx7Line30", found, 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("asyncResetOutputs", {lineValid, busy, readAddr, readSel, subIdx, lineIdx, last, frameDone, startOverrun}, 0);
      checkOutput("asyncResetLines", {currLine, prevLine}, 0);
      sb.delete();
      doneBase = doneCount;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("noDoneAfterReset", doneCount - doneBase, 0);
      checkOutput("idleAfterReset", busy, 0);
      applyStimulus('{curr: 2'd0, prev: 2'd2, readyPct: 100, expFirstAddr: 9'd0, expSecondAddr: 9'd256, expCycles: 4096});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gcbp_bram_reader.md
Name: gcbp_bram_reader

Overview:
- Read-side counterpart of the GCBP BRAM writer.
- After a frame's gray-coded bit-plane sub-images are stored in the 16-BRAM array, this block walks all 16 sub-images line by line. For each line it fetches the current-frame and previous-frame words from the same BRAM.
- It presents each line pair on a valid/ready stream to the downstream motion-matching engine.
- It sits between the BRAM array read port and the matcher.

Parameters:
- C_SUBIMAGE_HEIGHT, 64: lines per sub-image (line index 0..63).
- C_NUM_SUBIMAGES, 16: sub-images per frame, 4 vertical x 4 horizontal, one per BRAM.
- C_REGION_DEPTH, 128: BRAM words reserved per frame location.
- C_LINE_WIDTH, 128: bits per BRAM word / sub-image line.

Ports:
- i_clk  in  1  clock.
- i_resetn  in  1  asynchronous, active-high reset (despite the name).
- i_start  in  1  1-cycle pulse: begin reading a frame.
- i_curr_frame_loc  in  2  frame location of current frame; sampled on accepted i_start.
- i_prev_frame_loc  in  2  frame location of previous frame; sampled on accepted i_start.
- o_bram_array_read_addr  out  9  broadcast read address.
- o_bram_array_read_sel  out  4  BRAM select (= sub-image index); array muxes read data.
- i_bram_array_read_data  in  128  selected BRAM read data, valid 1 cycle after addr/sel.
- o_curr_line  out  128  current-frame line.
- o_prev_line  out  128  previous-frame line.
- o_subimage_idx  out  4  vert*4 + hori of presented line.
- o_line_idx  out  6  line within sub-image.
- o_line_valid  out  1  output pair valid.
- i_line_ready  in  1  downstream accepts pair.
- o_last  out  1  presented line is line 63 of sub-image 15.
- o_busy  out  1  frame read in progress.
- o_frame_done  out  1  1-cycle pulse after last pair accepted.
- o_start_overrun  out  1  1-cycle pulse: i_start arrived while busy.

Behaviour:
- Reset (async, any time, including mid-frame):
  - FSM to S_IDLE.
  - All outputs 0, including counters, latched locations, addr, sel and data registers.
  - Any in-flight pair is discarded.
- Address: o_bram_array_read_addr = loc*C_REGION_DEPTH + line_idx, 9 bits. Loc 0..3 all legal; no range check.
- Sub-image index = vert*4 + hori, matching the writer's one-hot write-enable bit order.
- FSM states:
  - S_IDLE: o_busy=0. On i_start, latch both locs, clear sub-image and line counters, go to S_ADDR_CURR.
  - S_ADDR_CURR: drive addr = curr_loc addr, sel = sub-image counter. Go to S_ADDR_PREV.
  - S_ADDR_PREV: capture i_bram_array_read_data into o_curr_line. Drive addr = prev_loc addr, same sel. Go to S_CAP_PREV.
  - S_CAP_PREV: capture read data into o_prev_line, load o_subimage_idx/o_line_idx, set o_line_valid. Go to S_OUT.
  - S_OUT: hold all outputs stable while o_line_valid && !i_line_ready.
    - On handshake: clear valid.
    - If line 63 of sub-image 15: pulse o_frame_done next cycle, go to S_IDLE.
    - Else: increment line, wrapping 63->0 with sub-image +1, and go to S_ADDR_CURR.
- Timing:
  - Read latency is 1 cycle (synchronous BRAM).
  - First o_line_valid appears 3 cycles after i_start.
  - Minimum 4 cycles per line; 4096 cycles per frame with ready tied high.
- o_busy = 1 in every state except S_IDLE, including the cycle after i_start. o_frame_done fires the cycle o_busy returns to 0.
- o_last = o_line_valid && idx==15 && line==63.
- i_start in S_IDLE is accepted. i_start in any other state is ignored (latched locs unchanged) and pulses o_start_overrun.
  - i_start on the same cycle as the final handshake counts as busy: it is ignored and overrun pulses.
- curr_loc == prev_loc is not an error; both words read identically.
- i_line_ready high when o_line_valid=0 has no effect.

Test Plan:
- Reset, then i_start with curr=1, prev=0, ready=1:
  - first addr 128 / sel 0, then addr 0.
  - o_line_valid at cycle 3 with idx 0 / line 0.
  - 1024 pairs total; o_frame_done exactly once, 4096 cycles after start; o_last only on idx 15 / line 63.
- BRAM model storing word = {sel, addr} pattern, curr=2, prev=1:
  - o_curr_line/o_prev_line match addr 256+line / 128+line on the correct sel for every line.
  - Line 63 -> 0 wrap increments sub-image.
- Random i_line_ready (30% high): outputs held stable while valid && !ready; no lost or duplicated pairs; order idx-major, line-minor.
- i_start pulsed at cycle 500 mid-frame: o_start_overrun 1 cycle, locs unchanged, sequence unaffected. i_start on the final handshake cycle also overruns.
- Assert i_resetn during S_OUT at sub-image 7 / line 30: outputs 0 immediately (asynchronous), no o_frame_done. Next i_start restarts at idx 0 / line 0.
- curr=prev=3: addresses 384..447 each read twice; o_curr_line == o_prev_line for all pairs.
